// File: rtl/rv_pkg.sv
// Shared LSU types: operation, FSM state and memory access size, plus
// alignment and store-data sizing helpers.
package rv_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HWORD = 2'd1,
    WORD  = 2'd2
  } mem_op_sz_e;

  typedef enum logic [1:0] {
    LSU_NONE  = 2'd0,
    LSU_LOAD  = 2'd1,
    LSU_STORE = 2'd2
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  function automatic logic is_aligned(mem_op_sz_e sz, logic [1:0] lsb);
    case (sz)
      HWORD:   is_aligned = (lsb[0] == 1'b0);
      WORD:    is_aligned = (lsb == 2'b00);
      default: is_aligned = 1'b1;
    endcase
  endfunction

  // Store data travels LSB-aligned; bytes above the access size are zeroed.
  function automatic logic [31:0] size_mask(mem_op_sz_e sz, logic [31:0] d);
    case (sz)
      BYTE:    size_mask = {24'h0, d[7:0]};
      HWORD:   size_mask = {16'h0, d[15:0]};
      default: size_mask = d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational size/sign extension of LSB-aligned load data; also usable
// on a load-forwarding path.
module lsu_extend
  import rv_pkg::*;
(
  input  logic [31:0] data_i,
  input  mem_op_sz_e  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (size_i)
      BYTE:    data_o = unsigned_i ? {24'h0, data_i[7:0]}
                                   : {{24{data_i[7]}}, data_i[7:0]};
      HWORD:   data_o = unsigned_i ? {16'h0, data_i[15:0]}
                                   : {{16{data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Memory-stage load/store initiator: alignment check, registered request,
// pipeline stall while outstanding, extended load data and access timeout.
module lsu_mem_if
  import rv_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_valid,
  input  lsu_op_e     i_op,
  input  mem_op_sz_e  i_mem_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic        o_mem_we,
  output logic        o_mem_re,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  output mem_op_sz_e  o_mem_size,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_data_ready,
  input  logic        i_mem_write_ready
);

  localparam logic [31:0] TO_LAST = (TimeoutCycles == 0) ? 32'd0 : 32'(TimeoutCycles - 1);
  localparam logic        TO_EN   = (TimeoutCycles != 0);

  lsu_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  mem_op_sz_e  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;
  logic [31:0] ext_data;
  logic        timeout_hit;

  lsu_extend u_extend (
    .data_i     (i_mem_data),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid && (i_op == LSU_LOAD || i_op == LSU_STORE)) begin
          if (!is_aligned(i_mem_size, i_addr[1:0])) begin
            mis_d = 1'b1;
          end else begin
            addr_d  = i_addr;
            size_d  = i_mem_size;
            uns_d   = i_unsigned;
            wdata_d = size_mask(i_mem_size, i_wdata);
            cnt_d   = 32'd0;
            state_d = (i_op == LSU_LOAD) ? READ : WRITE;
          end
        end
      end
      READ: begin
        if (i_mem_data_ready) begin
          rdata_d = ext_data;
          cnt_d   = 32'd0;
          state_d = RESP;
        end else if (timeout_hit) begin
          to_d    = 1'b1;
          cnt_d   = 32'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WRITE: begin
        if (i_mem_write_ready) begin
          cnt_d   = 32'd0;
          state_d = RESP;
        end else if (timeout_hit) begin
          to_d    = 1'b1;
          cnt_d   = 32'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP: begin
        cnt_d   = 32'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      addr_q  <= 32'd0;
      size_q  <= BYTE;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  // Strobes and status decode straight from the state so reset drops them at once.
  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == RESP);
  assign o_mem_re     = (state_q == READ);
  assign o_mem_we     = (state_q == WRITE);
  assign o_rdata      = rdata_q;
  assign o_misaligned = mis_q;
  assign o_timeout    = to_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_data   = wdata_q;
  assign o_mem_size   = size_q;

endmodule
